mccpu_ctrl: RTL and testbench
=============================

Name: mccpu_ctrl

Overview:
- Multi-cycle control sequencer for the next-generation MIPS core. Replaces the single-cycle combinational control path.
- Splits each instruction into FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with variable-latency instruction/data memory through a req/ready pair.
- Traps on illegal opcodes and memory timeouts.
- Drives the existing datapath selects (PC, RF, EXT, ALU, muxes) with the established encodings.

Parameters:
- ALUOP_W, 4, width of ALUOp.
- MEM_TIMEOUT, 255, max cycles waiting for mem_ready before trap; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- Op  in  6  instr[31:26] from instruction register
- Funct  in  6  instr[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_ifetch  out  1  1 = current request is instruction fetch
- MemWrite  out  2  00 none, 01 word, 10 byte
- LAddr  out  3  000 word, 001 signed byte
- IRWrite  out  1  latch instruction register
- PCWrite  out  1  update PC from NPC
- NPCOp  out  2  0 PC+4, 1 branch, 2 jump, 3 jr
- RegWrite  out  1  register file write strobe
- GPRSel  out  2  0 rd, 1 rt, 2 r31
- WDSel  out  2  0 aluout, 1 readdata, 2 PC+4
- EXTOp  out  1  1 sign-extend, 0 zero-extend
- ALUSrc  out  2  0 RD2, 1 Imm32, 2 shamt
- ALUOp  out  ALUOP_W  1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 SRL, 8 LUI
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 illegal instr, 10 memory timeout

Behaviour:
- Reset (rst=0, async): state=FETCH, trap=0, trap_cause=0, wait counter=0. All strobes (mem_req, IRWrite, PCWrite, RegWrite, MemWrite) are 0 while rst=0.
- Supported instructions:
  - R-type: add 20, sub 22, and 24, or 25, slt 2A, sll 00, srl 02, jr 08.
  - I-type: addi 08, ori 0D, lui 0F, lw 23, lb 20, sw 2B, sb 28, beq 04, bne 05.
  - J-type: j 02, jal 03.
  - Anything else is illegal.
- FETCH: mem_req=1, mem_ifetch=1. On mem_ready: IRWrite=1 for that cycle, go to DECODE. Otherwise stay.
- DECODE, one cycle:
  - Illegal instruction -> TRAP, cause 01.
  - j -> PCWrite, NPCOp=2, go to FETCH.
  - jal -> additionally RegWrite, GPRSel=2, WDSel=2.
  - Others -> EXEC.
- EXEC, one cycle, ALU selects valid:
  - beq/bne: PCWrite=1; NPCOp=1 if taken (beq: Zero=1, bne: Zero=0), else 0; go to FETCH.
  - jr: PCWrite, NPCOp=3, go to FETCH.
  - lw/lb/sw/sb: ALUOp=ADD, ALUSrc=1, EXTOp=1, go to MEM.
  - ALU instructions: go to WB.
- MEM: mem_req=1, mem_ifetch=0, MemWrite per store, LAddr per load. Outputs stay stable until mem_ready.
  - On mem_ready, loads -> WB.
  - On mem_ready, stores -> PCWrite, NPCOp=0, go to FETCH.
- WB, one cycle:
  - RegWrite=1, PCWrite=1, NPCOp=0.
  - R-type: GPRSel=0, WDSel=0.
  - I-type ALU: GPRSel=1, WDSel=0.
  - Loads: GPRSel=1, WDSel=1.
  - ALU selects are held from EXEC.
  - Go to FETCH.
- Extension: addi uses sign-extend. ori and lui use zero-extend. sll/srl use ALUSrc=2.
- Timeout: a counter increments each FETCH/MEM cycle with mem_ready=0 and clears on state change.
  - When counter reaches MEM_TIMEOUT with no mem_ready -> TRAP, cause 10.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins.
- TRAP: all strobes 0, trap=1. Only reset exits.
- Every completed instruction asserts PCWrite exactly once. RegWrite is never asserted for GPRSel selecting r0 semantics; the RF ignores writes to r0.
- Latency: R-type/I-ALU 4 cycles, load 5, store 4, branch/jr 3, j/jal 2 (zero-wait memory).

Optional Feature:
- Macro MCCPU_PERF_EN. When defined, two additional 32-bit outputs are added:
  - cycle_cnt: increments every cycle out of reset.
  - instret_cnt: increments on every PCWrite.
  - Both are async-reset to 0, wrap at 2^32, and freeze in TRAP.
- When undefined, the ports and counters do not exist.

Test Plan:
- Zero-wait memory, add r3,r1,r2 (Op 00, Funct 20) -> states FETCH,DECODE,EXEC,WB; WB has RegWrite=1, GPRSel=0, WDSel=0, ALUOp=1, PCWrite=1 with NPCOp=0.
- lw with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, LAddr=000, then WB with WDSel=1, GPRSel=1; total 8 cycles.
- beq with Zero=1, then bne with Zero=1 -> EXEC NPCOp=1, then NPCOp=0; both with PCWrite=1 and no RegWrite.
- jal -> DECODE asserts RegWrite, GPRSel=2, WDSel=2, NPCOp=2, PCWrite; next state FETCH.
- Op=3F -> TRAP with trap_cause=01, no strobes thereafter. Separately, MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> TRAP with cause 10 after 4 wait cycles.
- Assert rst low mid-MEM during a sw -> MemWrite and mem_req drop immediately (async) and state=FETCH. With MCCPU_PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle MIPS control sequencer with memory handshake and traps.
// Define MCCPU_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module mccpu_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_ifetch,
    output logic [1:0]         MemWrite,
    output logic [2:0]         LAddr,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         NPCOp,
    output logic               RegWrite,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               EXTOp,
    output logic [1:0]         ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
`ifdef MCCPU_PERF_EN
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt,
`endif
    output logic [2:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    // Counter only has to hold MEM_TIMEOUT-1; the next wait cycle traps.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic               r_alu;
    logic               i_alu;
    logic               is_ld;
    logic               is_st;
    logic               is_br;
    logic               is_jr;
    logic               is_j;
    logic               is_jal;
    logic               is_lb;
    logic               is_sb;
    logic               is_bne;
    logic               legal;
    logic               taken;
    logic [ALUOP_W-1:0] aop;
    logic [1:0]         asrc;
    logic               ext;

    always_comb begin
        r_alu  = 1'b0;
        i_alu  = 1'b0;
        is_ld  = 1'b0;
        is_st  = 1'b0;
        is_br  = 1'b0;
        is_jr  = 1'b0;
        is_j   = 1'b0;
        is_jal = 1'b0;
        is_lb  = 1'b0;
        is_sb  = 1'b0;
        is_bne = 1'b0;
        aop    = '0;
        asrc   = 2'd0;
        ext    = 1'b0;
        case (Op)
            6'h00: begin
                case (Funct)
                    6'h20: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(1);
                    end
                    6'h22: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(2);
                    end
                    6'h24: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(3);
                    end
                    6'h25: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(4);
                    end
                    6'h2A: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(5);
                    end
                    6'h00: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(6);
                        asrc  = 2'd2;
                    end
                    6'h02: begin
                        r_alu = 1'b1;
                        aop   = ALUOP_W'(7);
                        asrc  = 2'd2;
                    end
                    6'h08: is_jr = 1'b1;
                    default: ;
                endcase
            end
            6'h08: begin
                i_alu = 1'b1;
                aop   = ALUOP_W'(1);
                asrc  = 2'd1;
                ext   = 1'b1;
            end
            6'h0D: begin
                i_alu = 1'b1;
                aop   = ALUOP_W'(4);
                asrc  = 2'd1;
            end
            6'h0F: begin
                i_alu = 1'b1;
                aop   = ALUOP_W'(8);
                asrc  = 2'd1;
            end
            6'h23, 6'h20: begin
                is_ld = 1'b1;
                is_lb = (Op == 6'h20);
                aop   = ALUOP_W'(1);
                asrc  = 2'd1;
                ext   = 1'b1;
            end
            6'h2B, 6'h28: begin
                is_st = 1'b1;
                is_sb = (Op == 6'h28);
                aop   = ALUOP_W'(1);
                asrc  = 2'd1;
                ext   = 1'b1;
            end
            6'h04, 6'h05: begin
                is_br  = 1'b1;
                is_bne = (Op == 6'h05);
                aop    = ALUOP_W'(2);
                ext    = 1'b1;
            end
            6'h02: is_j = 1'b1;
            6'h03: is_jal = 1'b1;
            default: ;
        endcase
    end

    assign legal = r_alu | i_alu | is_ld | is_st | is_br | is_jr | is_j | is_jal;
    assign taken = is_bne ? !Zero : Zero;

    logic [CW-1:0] wait_cnt;
    logic [2:0]    nxt;
    logic          waiting;
    logic          timeout;
    logic          req;
    logic          ir_wr;
    logic          pc_wr;
    logic          rf_wr;
    logic [1:0]    mw;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting &&
                     (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt        = state;
        req        = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        rf_wr      = 1'b0;
        mw         = 2'b00;
        mem_ifetch = 1'b0;
        LAddr      = 3'b000;
        NPCOp      = 2'd0;
        GPRSel     = 2'd0;
        WDSel      = 2'd0;
        EXTOp      = 1'b0;
        ALUSrc     = 2'd0;
        ALUOp      = '0;
        unique case (state)
            S_FETCH: begin
                req        = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_wr = 1'b1;
                    nxt   = S_DECODE;
                end else if (timeout) begin
                    nxt = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    nxt = S_TRAP;
                end else if (is_j || is_jal) begin
                    pc_wr  = 1'b1;
                    NPCOp  = 2'd2;
                    rf_wr  = is_jal;
                    GPRSel = 2'd2;
                    WDSel  = 2'd2;
                    nxt    = S_FETCH;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                EXTOp  = ext;
                ALUSrc = asrc;
                ALUOp  = aop;
                if (is_br) begin
                    pc_wr = 1'b1;
                    NPCOp = taken ? 2'd1 : 2'd0;
                    nxt   = S_FETCH;
                end else if (is_jr) begin
                    pc_wr = 1'b1;
                    NPCOp = 2'd3;
                    nxt   = S_FETCH;
                end else if (is_ld || is_st) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                req    = 1'b1;
                EXTOp  = ext;
                ALUSrc = asrc;
                ALUOp  = aop;
                mw     = is_st ? (is_sb ? 2'b10 : 2'b01) : 2'b00;
                LAddr  = is_lb ? 3'b001 : 3'b000;
                if (mem_ready) begin
                    if (is_st) begin
                        pc_wr = 1'b1;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout) begin
                    nxt = S_TRAP;
                end
            end
            S_WB: begin
                EXTOp  = ext;
                ALUSrc = asrc;
                ALUOp  = aop;
                rf_wr  = 1'b1;
                pc_wr  = 1'b1;
                GPRSel = r_alu ? 2'd0 : 2'd1;
                WDSel  = is_ld ? 2'd1 : 2'd0;
                nxt    = S_FETCH;
            end
            S_TRAP: ;
            default: nxt = S_FETCH;
        endcase
    end

    // Strobes are forced low combinationally so reset takes effect mid-cycle.
    assign mem_req  = req & rst;
    assign IRWrite  = ir_wr & rst;
    assign PCWrite  = pc_wr & rst;
    assign RegWrite = rf_wr & rst;
    assign MemWrite = mw & {2{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state <= nxt;
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 1'b1;
            if ((state != S_TRAP) && (nxt == S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= (state == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

`ifdef MCCPU_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state != S_TRAP) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_wr)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl: randomized instruction streams against a cycle-list model.
// Memory wait states and Zero are drawn at random; traps are followed by reset.
`timescale 1ns/1ps
module tb_mccpu_ctrl;

    localparam int MT = 4;
    localparam int C_ILL = 0;
    localparam int C_R   = 1;
    localparam int C_JR  = 2;
    localparam int C_IA  = 3;
    localparam int C_LD  = 4;
    localparam int C_ST  = 5;
    localparam int C_BR  = 6;
    localparam int C_J   = 7;
    localparam int C_JAL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req;
    logic       mem_ifetch;
    logic [1:0] MemWrite;
    logic [2:0] LAddr;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] NPCOp;
    logic       RegWrite;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic       EXTOp;
    logic [1:0] ALUSrc;
    logic [3:0] ALUOp;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
`ifdef MCCPU_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    always #5 clk = ~clk;

    mccpu_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(MT)) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_ifetch (mem_ifetch),
        .MemWrite   (MemWrite),
        .LAddr      (LAddr),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .NPCOp      (NPCOp),
        .RegWrite   (RegWrite),
        .GPRSel     (GPRSel),
        .WDSel      (WDSel),
        .EXTOp      (EXTOp),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
`ifdef MCCPU_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .state      (state),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0] st;
        logic       rdy;
        logic       req;
        logic       ifch;
        logic [1:0] mw;
        logic [2:0] la;
        logic       irw;
        logic       pcw;
        logic [1:0] npc;
        logic       rw;
        logic [1:0] gs;
        logic [1:0] wd;
        logic       ext;
        logic [1:0] src;
        logic [3:0] aop;
        logic       trp;
        logic [1:0] cause;
        logic       cla;
        logic       calu;
        logic       cext;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        logic [3:0] aop;
        logic [1:0] src;
        logic       ext;
        logic       sub;
    } tab_t;

    tab_t tab[19];
    cyc_t q[$];
    int   cy_since = 0;
    int   pc_since = 0;

    task automatic fill_tab();
        tab[0]  = '{6'h00, 6'h20, C_R,   4'd1, 2'd0, 1'b0, 1'b0};
        tab[1]  = '{6'h00, 6'h22, C_R,   4'd2, 2'd0, 1'b0, 1'b0};
        tab[2]  = '{6'h00, 6'h24, C_R,   4'd3, 2'd0, 1'b0, 1'b0};
        tab[3]  = '{6'h00, 6'h25, C_R,   4'd4, 2'd0, 1'b0, 1'b0};
        tab[4]  = '{6'h00, 6'h2A, C_R,   4'd5, 2'd0, 1'b0, 1'b0};
        tab[5]  = '{6'h00, 6'h00, C_R,   4'd6, 2'd2, 1'b0, 1'b0};
        tab[6]  = '{6'h00, 6'h02, C_R,   4'd7, 2'd2, 1'b0, 1'b0};
        tab[7]  = '{6'h00, 6'h08, C_JR,  4'd0, 2'd0, 1'b0, 1'b0};
        tab[8]  = '{6'h08, 6'h00, C_IA,  4'd1, 2'd1, 1'b1, 1'b0};
        tab[9]  = '{6'h0D, 6'h00, C_IA,  4'd4, 2'd1, 1'b0, 1'b0};
        tab[10] = '{6'h0F, 6'h00, C_IA,  4'd8, 2'd1, 1'b0, 1'b0};
        tab[11] = '{6'h23, 6'h00, C_LD,  4'd1, 2'd1, 1'b1, 1'b0};
        tab[12] = '{6'h20, 6'h00, C_LD,  4'd1, 2'd1, 1'b1, 1'b1};
        tab[13] = '{6'h2B, 6'h00, C_ST,  4'd1, 2'd1, 1'b1, 1'b0};
        tab[14] = '{6'h28, 6'h00, C_ST,  4'd1, 2'd1, 1'b1, 1'b1};
        tab[15] = '{6'h04, 6'h00, C_BR,  4'd0, 2'd0, 1'b0, 1'b0};
        tab[16] = '{6'h05, 6'h00, C_BR,  4'd0, 2'd0, 1'b0, 1'b1};
        tab[17] = '{6'h02, 6'h00, C_J,   4'd0, 2'd0, 1'b0, 1'b0};
        tab[18] = '{6'h03, 6'h00, C_JAL, 4'd0, 2'd0, 1'b0, 1'b0};
    endtask

    function automatic int lookup(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < 19; i++)
            if (tab[i].op == op && (op != 6'h00 || tab[i].fn == fn))
                return i;
        return -1;
    endfunction

    function automatic cyc_t blank(input logic [2:0] s);
        cyc_t c;
        c = '{default: '0};
        c.st = s;
        return c;
    endfunction

    function automatic logic [31:0] pk(input cyc_t c);
        return {3'b0, c.st, c.trp, c.cause, c.req, c.ifch, c.mw, c.la,
                c.irw, c.pcw, c.npc, c.rw, c.gs, c.wd, c.ext, c.src, c.aop};
    endfunction

    task automatic push_trap(input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c = blank(3'd7);
            c.trp = 1'b1;
            c.cause = cause;
            q.push_back(c);
        end
    endtask

    // One instruction as the list of cycles it must produce.
    task automatic model(input int k, input logic z, input int fd,
                         input int md, output bit trapped);
        cyc_t c;
        tab_t t;
        trapped = 1'b0;
        t = '{default: '0};
        if (k >= 0) t = tab[k];
        for (int w = 1; w <= fd; w++) begin
            c = blank(3'd0);
            c.req = 1'b1;
            c.ifch = 1'b1;
            q.push_back(c);
            if (w == MT) begin
                push_trap(2'b10);
                trapped = 1'b1;
                return;
            end
        end
        c = blank(3'd0);
        c.req = 1'b1;
        c.ifch = 1'b1;
        c.rdy = 1'b1;
        c.irw = 1'b1;
        q.push_back(c);
        c = blank(3'd1);
        if (k < 0) begin
            q.push_back(c);
            push_trap(2'b01);
            trapped = 1'b1;
            return;
        end
        if (t.cls == C_J || t.cls == C_JAL) begin
            c.pcw = 1'b1;
            c.npc = 2'd2;
            if (t.cls == C_JAL) begin
                c.rw = 1'b1;
                c.gs = 2'd2;
                c.wd = 2'd2;
            end
            q.push_back(c);
            return;
        end
        q.push_back(c);
        c = blank(3'd2);
        c.aop = t.aop;
        c.src = t.src;
        c.ext = t.ext;
        if (t.cls == C_BR) begin
            c.pcw = 1'b1;
            c.npc = (z ^ t.sub) ? 2'd1 : 2'd0;
            q.push_back(c);
            return;
        end
        if (t.cls == C_JR) begin
            c.pcw = 1'b1;
            c.npc = 2'd3;
            q.push_back(c);
            return;
        end
        c.calu = 1'b1;
        c.cext = (t.cls != C_R);
        q.push_back(c);
        if (t.cls == C_LD || t.cls == C_ST) begin
            for (int w = 0; w <= md; w++) begin
                c = blank(3'd3);
                c.req = 1'b1;
                c.mw = (t.cls == C_ST) ? (t.sub ? 2'b10 : 2'b01) : 2'b00;
                c.la = t.sub ? 3'b001 : 3'b000;
                c.cla = (t.cls == C_LD);
                c.rdy = (w == md);
                if (c.rdy && t.cls == C_ST)
                    c.pcw = 1'b1;
                q.push_back(c);
                if (!c.rdy && w + 1 == MT) begin
                    push_trap(2'b10);
                    trapped = 1'b1;
                    return;
                end
            end
            if (t.cls == C_ST) return;
        end
        c = blank(3'd4);
        c.rw = 1'b1;
        c.pcw = 1'b1;
        c.gs = (t.cls == C_R) ? 2'd0 : 2'd1;
        c.wd = (t.cls == C_LD) ? 2'd1 : 2'd0;
        c.aop = t.aop;
        c.src = t.src;
        c.ext = t.ext;
        c.calu = (t.cls != C_LD);
        c.cext = (t.cls == C_IA);
        q.push_back(c);
    endtask

    task automatic compare(input cyc_t c, input string tag, input int i);
        cyc_t m;
        logic [31:0] obs;
        m = blank(3'b111);
        m.trp = 1'b1;
        m.cause = 2'b11;
        m.req = 1'b1;
        m.ifch = c.req;
        m.mw = 2'b11;
        m.la = c.cla ? 3'b111 : 3'b000;
        m.irw = 1'b1;
        m.pcw = 1'b1;
        m.npc = c.pcw ? 2'b11 : 2'b00;
        m.rw = 1'b1;
        m.gs = c.rw ? 2'b11 : 2'b00;
        m.wd = c.rw ? 2'b11 : 2'b00;
        m.ext = c.cext;
        m.src = c.calu ? 2'b11 : 2'b00;
        m.aop = c.calu ? 4'hF : 4'h0;
        obs = {3'b0, state, trap, trap_cause, mem_req, mem_ifetch, MemWrite,
               LAddr, IRWrite, PCWrite, NPCOp, RegWrite, GPRSel, WDSel,
               EXTOp, ALUSrc, ALUOp};
        check($sformatf("%s#%0d st%0d", tag, i, c.st), obs & pk(m), pk(c) & pk(m));
    endtask

    task automatic run(input int n, input string tag);
        cyc_t c;
        int i;
        i = 0;
        while (q.size() > 0 && (n < 0 || i < n)) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            @(negedge clk);
            compare(c, tag, i);
`ifdef MCCPU_PERF_EN
            check($sformatf("%s#%0d cyc", tag, i), cycle_cnt, cy_since);
            check($sformatf("%s#%0d ret", tag, i), instret_cnt, pc_since);
`endif
            if (c.st != 3'd7) cy_since++;
            if (c.pcw) pc_since++;
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_state", {29'b0, state}, 32'd0);
        check("rst_strobes",
              {24'b0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite, trap, trap_cause[1]},
              32'd0);
        check("rst_cause", {30'b0, trap_cause}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
`ifdef MCCPU_PERF_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
        rst = 1'b1;
        cy_since = 0;
        pc_since = 0;
        q.delete();
    endtask

    task automatic issue(input int k, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int fd, input int md, input string tag);
        bit tr;
        Op = op;
        Funct = fn;
        Zero = z;
        model(k, z, fd, md, tr);
        run(-1, tag);
        if (tr) do_reset();
    endtask

    initial begin
        int k;
        int fd;
        int md;
        logic [5:0] op;
        logic [5:0] fn;
        bit tr;
        fill_tab();
        do_reset();

        issue(0, 6'h00, 6'h20, 1'b0, 0, 0, "add");
        issue(11, 6'h23, 6'h11, 1'b0, 0, 3, "lw_wait3");
        issue(15, 6'h04, 6'h00, 1'b1, 0, 0, "beq_z1");
        issue(16, 6'h05, 6'h00, 1'b1, 0, 0, "bne_z1");
        issue(18, 6'h03, 6'h00, 1'b0, 0, 0, "jal");
        issue(-1, 6'h3F, 6'h00, 1'b0, 0, 0, "ill_3f");
        issue(0, 6'h00, 6'h20, 1'b0, 10, 0, "fetch_timeout");
        issue(12, 6'h20, 6'h00, 1'b0, 1, MT, "lb_mem_timeout");

        Op = 6'h2B;
        Funct = 6'h00;
        Zero = 1'b0;
        model(13, 1'b0, 0, 3, tr);
        run(4, "sw_mid");
        check("sw_mid_active", {29'b0, mem_req, MemWrite}, 32'b101);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (lookup(op, fn) >= 0);
                k = -1;
            end else begin
                k = $urandom_range(0, 18);
                op = tab[k].op;
                fn = (op == 6'h00) ? tab[k].fn : 6'($urandom);
            end
            fd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            md = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            issue(k, op, fn, 1'($urandom), fd, md, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
